demode_uart_byte_rx: RTL and testbench

Serial byte receiver at the front of the demodulator control path. Oversamples the asynchronous `rx` pin, validates start and stop bits with 3-sample majority voting, and delivers 8N1 bytes LSB-first. It feeds the packet parser, which uses the `m_rx_busy` falling edge as its "byte ready" event. `m_rx_valid` and `m_rx_ferr` strobes are added for other consumers.

---
 rtl/demode_uart_pkg.sv | 27 ++
 rtl/demode_uart_baud_tick.sv | 42 ++++
 rtl/demode_uart_byte_rx.sv | 149 ++++++++++++++
 tb/tb_demode_uart_byte_rx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demode_uart_pkg.sv
// Shared definitions for the demodulator UART receive path and packet parser.
package demode_uart_pkg;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BRK
    } rx_state_e;

    // Oversample ratio and the centre sub-tick of each bit.
    localparam int OVS        = 16;
    localparam int SAMPLE_MID = 8;

    // Packet framing bytes shared with the parser.
    localparam logic [7:0] PROTO_SOF = 8'h28;
    localparam logic [7:0] PROTO_EOF = 8'h29;
    localparam logic [7:0] PROTO_ESC = 8'h2A;

    // Majority of three samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/demode_uart_baud_tick.sv
// Oversample tick generator: a DIV-clock divider plus a running tick index.
// clr restarts both so that tick 0 lands DIV clocks after the clear cycle.
module demode_uart_baud_tick #(
    parameter int DIV  = 27,
    parameter int IDXW = 8
) (
    input  logic            aclk,
    input  logic            rstn,
    input  logic            clr,
    output logic            tick,
    output logic [IDXW-1:0] tick_idx
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IDXW-1:0] idx_q, idx_d;

    // Divider wrap produces a tick; the index advances once per tick.
    always_comb begin
        tick  = (cnt_q == CW'(DIV - 1)) && !clr;
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        idx_d = tick ? idx_q + IDXW'(1) : idx_q;
        if (clr) begin
            cnt_d = '0;
            idx_d = '0;
        end
    end

    // Divider and index registers.
    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign tick_idx = idx_q;

endmodule

// File: rtl/demode_uart_byte_rx.sv
// 8N1 serial byte receiver: 16x oversampling, 3-sample majority per bit,
// break lockout after a framing error. Busy falls together with the strobe
// and the data update so the parser can use busy-fall as "byte ready".
module demode_uart_byte_rx
    import demode_uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200,
    parameter int OVS    = 16
) (
    input  logic       aclk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] m_rx_data,
    output logic       m_rx_busy,
    output logic       m_rx_valid,
    output logic       m_rx_ferr
);
    // Rounded clocks per oversample tick.
    localparam int DIV_RAW = (CLK_HZ + BAUD * (OVS / 2)) / (BAUD * OVS);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;

    logic [1:0] sync_q, sync_d;
    logic       rxs;
    rx_state_e  state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [1:0] smp_q, smp_d;
    logic [7:0] data_q, data_d;
    logic       busy_q, busy_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;
    logic       clr;
    logic       tick;
    logic [7:0] tick_idx;
    logic [3:0] bit_idx;
    logic [3:0] sub_idx;
    logic       vote;

    demode_uart_baud_tick #(
        .DIV  (DIV),
        .IDXW (8)
    ) u_tick (
        .aclk     (aclk),
        .rstn     (rstn),
        .clr      (clr),
        .tick     (tick),
        .tick_idx (tick_idx)
    );

    assign bit_idx = tick_idx[7:4];
    assign sub_idx = tick_idx[3:0];
    assign rxs     = sync_q[1];
    assign vote    = maj3(smp_q[0], smp_q[1], rxs);

    // Two-stage synchronizer shift.
    always_comb begin
        sync_d = {sync_q[0], rx};
    end

    // Synchronizer, idle-high out of reset so reset release is not a start bit.
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Next-state, sampling and output-strobe logic.
    always_comb begin
        // NOTE: every output is defaulted first so no path can infer a latch.
        state_d = state_q;
        shreg_d = shreg_q;
        smp_d   = smp_q;
        data_d  = data_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                clr = 1'b1;
                if (!rxs) state_d = ST_START;
            end
            ST_START, ST_DATA, ST_STOP: begin
                if (tick) begin
                    if (sub_idx == 4'(SAMPLE_MID - 1)) smp_d[0] = rxs;
                    if (sub_idx == 4'(SAMPLE_MID))     smp_d[1] = rxs;
                    if (sub_idx == 4'(SAMPLE_MID + 1)) begin
                        if (state_q == ST_START) begin
                            if (!vote) begin
                                state_d = ST_DATA;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else if (state_q == ST_DATA) begin
                            shreg_d = {vote, shreg_q[7:1]};
                            if (bit_idx == 4'd8) state_d = ST_STOP;
                        end else begin
                            busy_d = 1'b0;
                            if (vote) begin
                                data_d  = shreg_q;
                                valid_d = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
                                ferr_d  = 1'b1;
                                state_d = ST_BRK;
                            end
                        end
                    end
                end
            end
            ST_BRK: begin
                clr = 1'b1;
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            smp_q   <= 2'b11;
            data_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            smp_q   <= smp_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign m_rx_data  = data_q;
    assign m_rx_busy  = busy_q;
    assign m_rx_valid = valid_q;
    assign m_rx_ferr  = ferr_q;

endmodule

// File: tb/tb_demode_uart_byte_rx.sv
// Bench for demode_uart_byte_rx at DIV = 1 (16 clocks per bit). The pin is
// recorded per cycle; a reference model then scans that record with the
// receive rules (detect, majority votes at bit centres, break lockout) and
// the predicted busy/strobe/data timeline is compared cycle by cycle.
module tb_demode_uart_byte_rx;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int DIV    = (CLK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int MAXC   = 8192;

    logic       aclk = 1'b0;
    logic       rstn;
    logic       rx;
    logic [7:0] m_rx_data;
    logic       m_rx_busy;
    logic       m_rx_valid;
    logic       m_rx_ferr;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int frame_start = 0;

    bit         rx_hist  [MAXC];
    logic       ob_busy  [MAXC];
    logic       ob_valid [MAXC];
    logic       ob_ferr  [MAXC];
    logic [7:0] ob_data  [MAXC];
    logic       ex_busy  [MAXC];
    int         ex_strb  [MAXC];
    logic [7:0] ex_byte  [MAXC];
    logic [7:0] ex_data  [MAXC];

    demode_uart_byte_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .OVS    (16)
    ) dut (
        .aclk       (aclk),
        .rstn       (rstn),
        .rx         (rx),
        .m_rx_data  (m_rx_data),
        .m_rx_busy  (m_rx_busy),
        .m_rx_valid (m_rx_valid),
        .m_rx_ferr  (m_rx_ferr)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    // Record pin and outputs mid-cycle.
    always @(negedge aclk) begin
        if (cyc < MAXC) begin
            rx_hist[cyc]  <= rx;
            ob_busy[cyc]  <= m_rx_busy;
            ob_valid[cyc] <= m_rx_valid;
            ob_ferr[cyc]  <= m_rx_ferr;
            ob_data[cyc]  <= m_rx_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk);
            #1 rx = 1'b1;
        end
    endtask

    task automatic drive_low(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk);
            #1 rx = 1'b0;
        end
    endtask

    // One 8N1 frame, optionally with a one-clock flip inside slot flip_slot
    // (0 = start, 1..8 = data, 9 = stop), optionally cut short at n_cyc.
    task automatic send_frame(input logic [7:0] b, input logic stop_v = 1'b1,
                              input int flip_slot = -1, input int flip_off = 0,
                              input int n_cyc = 160);
        logic [9:0] f;
        f = {stop_v, b, 1'b0};
        for (int i = 0; i < n_cyc; i++) begin
            @(posedge aclk);
            #1;
            rx = ((i / 16) == flip_slot && (i % 16) == flip_off) ? ~f[i / 16] : f[i / 16];
            if (i == 0) frame_start = cyc;
        end
    endtask

    // Synchronized line as seen by the receiver in cycle c (sync resets to 1).
    function automatic bit rxs_at(input int c, input int rel);
        if (c - 2 < rel) return 1'b1;
        return rx_hist[c - 2];
    endfunction

    // Majority of the s = 7, 8, 9 samples of bit b for a frame detected at d.
    function automatic bit vote(input int d, input int b, input int rel);
        int n;
        n = 0;
        for (int s = 7; s <= 9; s++) n += int'(rxs_at(d + (16 * b + s + 1) * DIV, rel));
        return n >= 2;
    endfunction

    task automatic run_model(input int rel, input int stop);
        int c, d, e;
        logic [7:0] byt, cur;
        for (int i = rel; i < stop; i++) begin
            ex_busy[i] = 1'b0;
            ex_strb[i] = 0;
            ex_byte[i] = 8'h00;
        end
        c = rel;
        while (c < stop) begin
            if (rxs_at(c, rel)) begin
                c++;
            end else begin
                d = c;
                if (vote(d, 0, rel)) begin
                    c = d + 10 * DIV + 1;
                end else begin
                    byt = 8'h00;
                    for (int b = 1; b <= 8; b++) byt[b - 1] = vote(d, b, rel);
                    e = d + 154 * DIV + 1;
                    for (int i = d + 10 * DIV + 1; i < e && i < stop; i++) ex_busy[i] = 1'b1;
                    if (e < stop) begin
                        ex_strb[e] = vote(d, 9, rel) ? 1 : 2;
                        ex_byte[e] = byt;
                    end
                    c = e;
                    if (!vote(d, 9, rel)) begin
                        while (c < stop && !rxs_at(c, rel)) c++;
                        c++;
                    end
                end
            end
        end
        cur = 8'h00;
        for (int i = rel; i < stop; i++) begin
            if (ex_strb[i] == 1) cur = ex_byte[i];
            ex_data[i] = cur;
        end
    endtask

    task automatic compare_seg(input string seg, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            check($sformatf("%s_busy@%0d", seg, i), 32'(ob_busy[i]), 32'(ex_busy[i]));
            check($sformatf("%s_valid@%0d", seg, i), 32'(ob_valid[i]), 32'(ex_strb[i] == 1));
            check($sformatf("%s_ferr@%0d", seg, i), 32'(ob_ferr[i]), 32'(ex_strb[i] == 2));
            check($sformatf("%s_data@%0d", seg, i), 32'(ob_data[i]), 32'(ex_data[i]));
        end
    endtask

    function automatic int count_hi(input int sel, input int lo, input int hi);
        int n;
        n = 0;
        for (int i = lo; i < hi; i++) begin
            if (sel == 0 && ob_busy[i] === 1'b1) n++;
            if (sel == 1 && ob_valid[i] === 1'b1) n++;
            if (sel == 2 && ob_ferr[i] === 1'b1) n++;
        end
        return n;
    endfunction

    initial begin
        int rel1, rel2, ra, end_c, f1, g0;
        logic [7:0] rb;

        rstn = 1'b0;
        rx   = 1'b1;
        repeat (4) @(posedge aclk);
        @(negedge aclk);
        check("rst_data",  32'(m_rx_data),  32'h0);
        check("rst_busy",  32'(m_rx_busy),  32'h0);
        check("rst_valid", 32'(m_rx_valid), 32'h0);
        check("rst_ferr",  32'(m_rx_ferr),  32'h0);
        @(posedge aclk);
        #1 rstn = 1'b1;
        rel1 = cyc;
        idle($urandom_range(16, 40));

        // Clean byte.
        send_frame(8'hA5);
        f1 = frame_start;
        @(negedge aclk);
        check("data_a5", 32'(m_rx_data), 32'hA5);
        idle($urandom_range(16, 40));

        // Back-to-back bytes.
        send_frame(8'h28);
        @(negedge aclk);
        check("data_28", 32'(m_rx_data), 32'h28);
        send_frame(8'h2A);
        @(negedge aclk);
        check("data_2a", 32'(m_rx_data), 32'h2A);
        send_frame(8'h01);
        @(negedge aclk);
        check("data_01", 32'(m_rx_data), 32'h01);
        idle(30);

        // Short glitch.
        g0 = cyc + 1;
        drive_low(3);
        idle(40);
        check("glitch_data", 32'(m_rx_data), 32'h01);

        // Framing error followed by a long break, then a good byte.
        send_frame(8'h3C, 1'b0);
        drive_low(40 * 16);
        @(negedge aclk);
        check("ferr_data_held", 32'(m_rx_data), 32'h01);
        idle(32);
        send_frame(8'h55);
        @(negedge aclk);
        check("data_55", 32'(m_rx_data), 32'h55);
        idle($urandom_range(4, 30));

        // Data bit 3 is frame slot 4; pin offset 9 in the slot is the s = 8 sample.
        send_frame(8'h0F, 1'b1, 4, 9);
        @(negedge aclk);
        check("data_0f_vote", 32'(m_rx_data), 32'h0F);
        idle($urandom_range(4, 30));

        // Random bytes with random gaps (including none).
        for (int k = 0; k < 4; k++) begin
            rb = 8'($urandom_range(0, 255));
            send_frame(rb);
            @(negedge aclk);
            check($sformatf("data_rand%0d", k), 32'(m_rx_data), 32'(rb));
            idle($urandom_range(0, 20));
        end

        // Reset in the middle of data bit 4.
        send_frame(8'($urandom_range(0, 255)), 1'b1, -1, 0, 16 * 5 + 8);
        @(posedge aclk);
        #1;
        rstn = 1'b0;
        rx   = 1'b1;
        ra   = cyc;
        repeat (6) @(posedge aclk);
        #1 rstn = 1'b1;
        rel2 = cyc;
        idle(20);
        send_frame(8'h77);
        @(negedge aclk);
        check("data_77", 32'(m_rx_data), 32'h77);
        idle(40);
        end_c = cyc;
        repeat (2) @(posedge aclk);

        // Directed properties.
        check("a5_busy_len", 32'(count_hi(0, f1, f1 + 170)), 32'd144);
        check("glitch_busy", 32'(count_hi(0, g0, g0 + 43)), 32'd0);
        check("seg1_valid_cnt", 32'(count_hi(1, rel1, ra)), 32'd10);
        check("seg1_ferr_cnt", 32'(count_hi(2, rel1, ra)), 32'd1);
        check("seg2_valid_cnt", 32'(count_hi(1, rel2, end_c + 1)), 32'd1);
        check("seg2_ferr_cnt", 32'(count_hi(2, rel2, end_c + 1)), 32'd0);
        for (int i = ra; i < rel2; i++) begin
            check($sformatf("inrst_out@%0d", i),
                  32'({ob_data[i], ob_busy[i], ob_valid[i], ob_ferr[i]}), 32'h0);
        end

        // Cycle-by-cycle comparison against the reference model.
        run_model(rel1, ra);
        compare_seg("seg1", rel1, ra);
        run_model(rel2, end_c + 1);
        compare_seg("seg2", rel2, end_c + 1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
